// File: rtl/bit_enumerator.sv
// Expands a word into a stream of set-bit indices, LSB first, one beat per cycle.
// Zero words produce a single out_none beat so every word ends with exactly one out_last.
module bit_enumerator #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W:0]   out_count,
  output logic             out_last,
  output logic             out_none,
  output logic             dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid and
  // the payload stay stable until taken, and ready never depends on valid of the other side.
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [IDX_W:0]   ord;
  logic [WIDTH-1:0] pend_clr;
  logic [IDX_W-1:0] lsb_idx;
  logic             has_bits;
  logic             fire_in;
  logic             fire_out;

  assign pend_clr = pend & (pend - WIDTH'(1));
  assign has_bits = |pend;

  always_comb begin
    lsb_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend[i]) lsb_idx = IDX_W'(i);
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == EMIT);
  assign out_none  = out_valid && !has_bits;
  assign out_last  = out_valid && (pend_clr == '0);
  assign out_index = (out_valid && has_bits) ? lsb_idx : '0;
  assign out_count = (out_valid && has_bits) ? (ord + (IDX_W+1)'(1)) : '0;
  assign dbg_state = state;

  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      ord   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_in) begin
            pend  <= in_data;
            ord   <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (fire_out) begin
            pend <= pend_clr;
            ord  <= ord + (IDX_W+1)'(1);
            if (out_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_enumerator.sv
// Bench for bit_enumerator: vector table, hand-written stall/reset sequences and
// random words checked against a popcount/bit-scan reference model.
module tb_bit_enumerator;
  localparam int WIDTH = 32;
  localparam int IDX_W = 5;
  localparam int BW    = 2 + (IDX_W + 1) + IDX_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0]   out_count;
  logic             out_last;
  logic             out_none;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] exp_q[$];

  bit_enumerator #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_count(out_count), .out_last(out_last), .out_none(out_none), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan the word for set bits, number them 1..popcount.
  task automatic build_expected(input logic [WIDTH-1:0] data);
    int pc;
    int n;
    pc = $countones(data);
    n = 0;
    exp_q.delete();
    if (pc == 0) begin
      exp_q.push_back({1'b1, 1'b1, (IDX_W+1)'(0), IDX_W'(0)});
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (data[i]) begin
          n++;
          exp_q.push_back({1'b0, (n == pc), (IDX_W+1)'(n), IDX_W'(i)});
        end
      end
    end
  endtask

  // mode 0: out_ready always high; mode 1: random out_ready
  task automatic run_word(input logic [WIDTH-1:0] data, input int mode,
                          output int beats, output logic [IDX_W-1:0] last_idx,
                          output logic [IDX_W:0] last_cnt);
    int n;
    int cyc;
    logic [BW-1:0] act;
    beats = 0;
    last_idx = '0;
    last_cnt = '0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(in_ready == 1'b1, "in_ready_before_word", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = data;
    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    build_expected(data);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      act = {out_none, out_last, out_count, out_index};
      check(out_valid == 1'b1 && act == exp_q[0], "beat", 64'({out_valid, act}), 64'({1'b1, exp_q[0]}));
      check(in_ready == 1'b0, "in_ready_emit", 64'(in_ready), 64'd0);
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        beats++;
        last_idx = out_index;
        last_cnt = out_count;
        void'(exp_q.pop_front());
      end
    end
    check(exp_q.size() == 0, "word_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check(out_valid == 1'b0 && in_ready == 1'b1, "bubble_idle",
          64'({out_valid, in_ready}), 64'b01);
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    int               beats;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W:0]   last_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int beats;
    logic [IDX_W-1:0] li;
    logic [IDX_W:0]   lc;
    logic [WIDTH-1:0] w;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check({in_ready, out_valid, out_index, out_count, out_last, out_none} == '0, "reset_outputs",
          64'({in_ready, out_valid, out_index, out_count, out_last, out_none}), 64'd0);
    rst = 1'b0;
    #1;
    check(in_ready == 1'b1, "in_ready_after_reset", 64'(in_ready), 64'd1);

    vecs[0] = '{32'd1299704331, 18, 5'd30, 6'd18};
    vecs[1] = '{32'h0000_0000,   1, 5'd0,  6'd0};
    vecs[2] = '{32'h8000_0000,   1, 5'd31, 6'd1};
    vecs[3] = '{32'hFFFF_FFFF,  32, 5'd31, 6'd32};
    vecs[4] = '{32'h0000_0014,   2, 5'd4,  6'd2};
    vecs[5] = '{32'h0000_0001,   1, 5'd0,  6'd1};
    for (int v = 0; v < 6; v++) begin
      run_word(vecs[v].data, 0, beats, li, lc);
      check(beats == vecs[v].beats, "table_beats", 64'(beats), 64'(vecs[v].beats));
      check(li == vecs[v].last_idx, "table_last_index", 64'(li), 64'(vecs[v].last_idx));
      check(lc == vecs[v].last_cnt, "table_last_count", 64'(lc), 64'(vecs[v].last_cnt));
    end

    // Backpressure: 0x14 stalls on its first beat while a second word is offered.
    in_valid = 1'b1;
    in_data = 32'h0000_0014;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_data = 32'h0000_00FF;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check({out_valid, out_index, out_count, out_last, out_none, in_ready} == {1'b1, 5'd2, 6'd1, 1'b0, 1'b0, 1'b0},
            "stall_hold", 64'({out_valid, out_index, out_count, out_last, out_none, in_ready}),
            64'({1'b1, 5'd2, 6'd1, 1'b0, 1'b0, 1'b0}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({out_valid, out_index, out_count, out_last} == {1'b1, 5'd4, 6'd2, 1'b1}, "stall_release",
          64'({out_valid, out_index, out_count, out_last}), 64'({1'b1, 5'd4, 6'd2, 1'b1}));
    in_valid = 1'b0;
    in_data = '0;
    @(negedge clk);
    check(out_valid == 1'b0 && in_ready == 1'b1, "stall_end_idle",
          64'({out_valid, in_ready}), 64'b01);

    // Asynchronous reset partway through an all-ones word.
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (5) @(negedge clk);
    check(out_index == 5'd4 && out_count == 6'd5, "pre_reset_beat",
          64'({out_index, out_count}), 64'({5'd4, 6'd5}));
    #2;
    rst = 1'b1;
    #1;
    check({in_ready, out_valid, out_index, out_count, out_last, out_none} == '0, "async_reset_outputs",
          64'({in_ready, out_valid, out_index, out_count, out_last, out_none}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check(in_ready == 1'b1, "in_ready_after_midreset", 64'(in_ready), 64'd1);
    run_word(32'h0000_0001, 0, beats, li, lc);
    check(beats == 1 && li == 5'd0 && lc == 6'd1, "post_reset_word",
          64'({8'(beats), li, lc}), 64'({8'd1, 5'd0, 6'd1}));

    // Random words of varying density with random backpressure.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: w = $urandom() & $urandom() & $urandom();
        1: w = $urandom() | $urandom();
        2: w = (r % 8 == 0) ? '0 : (32'h1 << $urandom_range(0, 31));
        default: w = $urandom();
      endcase
      run_word(w, 1, beats, li, lc);
      check(beats == (w == '0 ? 1 : $countones(w)), "rand_beats",
            64'(beats), 64'(w == '0 ? 1 : $countones(w)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
